ex_wb_stage: RTL and testbench
==============================

# ex_wb_stage

Writeback-side pipeline stage directly downstream of the EX-stage control decode in the 3-stage CPU. It does four things:
- registers the EX-stage result and control into the WB stage;
- owns the HI/LO architectural registers and the GPIO output register;
- synchronizes the GPIO input pins;
- produces the final register-file write port (`regwrite_WB`, `regdest_WB`, `writedata_WB`).

## Interface
- `DATA_W`, 32, datapath width
- `SYNC_STAGES`, 2, flops in the `gpio_in` synchronizer (≥2)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `instruction_EX` in 32: EX instruction; rt = [20:16], rd = [15:11]
- `alu_lo_EX` in DATA_W: ALU result (low word for mult/multu)
- `alu_hi_EX` in DATA_W: ALU high word (valid only with `enhilo_EX`)
- `regwrite_EX` in 1: EX requests a register write
- `regsel_EX` in 2: 0 = ALU, 1 = HI, 2 = LO, 3 = reserved (treated as ALU)
- `enhilo_EX` in 1: load HI/LO
- `rdrt_EX` in 1: destination select, 1 = rt, 0 = rd
- `GPIO_OUT` in 1: load GPIO output register
- `GPIO_IN` in 1: write synchronized GPIO input to the destination
- `flush_EX` in 1: kill the EX instruction (bubble)
- `gpio_in` in DATA_W: asynchronous external pins
- `regwrite_WB` out 1: register-file write enable
- `regdest_WB` out 5: register-file write address
- `writedata_WB` out DATA_W: register-file write data
- `hi_q`, `lo_q` out DATA_W: architectural HI/LO
- `gpio_out` out DATA_W: GPIO output register

## Operation
- **Reset:** asserting `rst` low, at any time including mid-instruction, immediately clears all state: WB pipeline registers, `hi_q`, `lo_q`, `gpio_out`, and the synchronizer. All outputs read 0.
- **Kill:** an instruction is killed when `flush_EX` = 1. A killed instruction causes no state change except the synchronizer, which always shifts.
- **HI/LO load:** on an edge with `enhilo_EX` = 1 and not killed, `hi_q` ← `alu_hi_EX` and `lo_q` ← `alu_lo_EX`. The load happens at the end of EX, not in WB.
- **GPIO output:** on an edge with `GPIO_OUT` = 1 and not killed, `gpio_out` ← `alu_lo_EX`. `gpio_out` holds otherwise.
- **Destination:** `regdest_WB` ← `rdrt_EX` ? `instruction_EX[20:16]` : `instruction_EX[15:11]`.
- **Write enable:** `regwrite_WB` ← `regwrite_EX` & ~`flush_EX` & (dest ≠ 0). Writes to $0 are suppressed.
- **Write-data mux**, evaluated in WB from registered selects, highest priority first:
  - `GPIO_IN_WB`: synchronized GPIO sample captured at the EX→WB edge;
  - `regsel_WB` = 1: `hi_q`;
  - `regsel_WB` = 2: `lo_q`;
  - otherwise: registered ALU result.
  
  `GPIO_IN` overrides `regsel` because the GPIO-read decode also drives `regsel` = 1.
- **Simultaneous loads:** `enhilo_EX` and `GPIO_OUT` asserted together perform both loads independently.

## Timing
- **EX→WB latency:** 1 cycle. `writedata_WB`, `regdest_WB` and `regwrite_WB` are valid the cycle after the instruction is in EX.
- **HI/LO visibility:** `hi_q`/`lo_q` update on the edge ending the mult's EX cycle. An mfhi/mflo issued in the very next EX cycle reads the new value in its WB, so no stall is needed.
- **GPIO output:** `gpio_out` updates on the edge ending the EX cycle of the srl-with-shamt-0 instruction.
- **GPIO input latency:** an external change is visible to a GPIO read after `SYNC_STAGES` edges. The read value is the synchronizer output sampled at the EX→WB edge.
- **`writedata_WB`:** combinational from WB registers and `hi_q`/`lo_q`. No extra cycle.
- **Reset release:** the first edge after `rst` goes high behaves as a normal edge.

## Structure
- **Shared package `cpu_pkg`:**
  - `regsel_t` enum: `REGSEL_ALU` = 0, `REGSEL_HI` = 1, `REGSEL_LO` = 2;
  - `DATA_W` and `REG_ADDR_W` (5) constants;
  - `REG_ZERO` constant.
- **Sub-module `gpio_sync`:** parameterized `SYNC_STAGES` × `DATA_W` flop chain with the same async active-low reset.
- **Top:** the EX/WB pipeline register, HI/LO and `gpio_out` register logic, and the write mux live in `ex_wb_stage`.

## Test plan
- **Mult then mfhi/mflo:**
  - Stimulus: mult with `alu_hi_EX` = 0x0000_0001, `alu_lo_EX` = 0xFFFF_FFFE, `enhilo_EX` = 1, `regwrite_EX` = 0. Next cycle: mfhi, `regsel` = 1, rd = 8. Next: mflo, rd = 9.
  - Required: WB writes `r8` = 0x1 and `r9` = 0xFFFF_FFFE. The mult itself has `regwrite_WB` = 0.
- **GPIO write:** srl (shamt 0) with `alu_lo_EX` = 0xA5A5_0000, `GPIO_OUT` = 1 → `gpio_out` = 0xA5A5_0000 one edge later, holding through 10 idle cycles.
- **GPIO read:**
  - Stimulus: `gpio_in` = 0x1234_5678 applied ≥2 cycles earlier; sra (shamt 0) with `GPIO_IN` = 1, `regsel` = 1, rd = 3, while `hi_q` = 0xDEAD.
  - Required: `writedata_WB` = 0x1234_5678 (not 0xDEAD) and `regdest_WB` = 3.
- **Destination select and $0:**
  - addi with `rdrt` = 1, rt = 5, `alu_lo_EX` = 7 → `regdest_WB` = 5, data 7, `regwrite_WB` = 1.
  - Same instruction with rt = 0 → `regwrite_WB` = 0.
- **Flush:** mult with `enhilo_EX` = 1 and `flush_EX` = 1 → `hi_q`/`lo_q` unchanged and `regwrite_WB` = 0.
- **Async reset mid-operation:** with `gpio_out` = 0xFF and `hi_q` = 0x55, drop `rst` between edges → all outputs 0 immediately, before any clock edge. Release → normal operation resumes on the next instruction.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the 3-stage CPU datapath.
//   regsel_t   : WB write-data source select coming from EX decode
//   DATA_W     : datapath width
//   REG_ADDR_W : register-file address width
//   REG_ZERO   : address of the hard-wired zero register
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // Encoding 2'd3 is reserved and falls through to the ALU source.
  typedef enum logic [1:0] {
    REGSEL_ALU = 2'd0,
    REGSEL_HI  = 2'd1,
    REGSEL_LO  = 2'd2
  } regsel_t;

endpackage

// File: rtl/gpio_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync
// Multi-flop synchronizer for the asynchronous GPIO input pins. Every bit goes
// through SYNC_STAGES flops; the chain shifts on every edge regardless of what
// the pipeline is doing.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset, clears every stage
//   d   : raw external pins
//   q   : synchronized value (last stage)
// -----------------------------------------------------------------------------
module gpio_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/ex_wb_stage.sv
// -----------------------------------------------------------------------------
// ex_wb_stage
// EX->WB pipeline register plus the architectural HI/LO and GPIO output
// registers, the GPIO input synchronizer and the final register-file write
// port.
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   instruction_EX : EX instruction (rt = [20:16], rd = [15:11])
//   alu_lo_EX      : ALU result / low word of mult
//   alu_hi_EX      : high word of mult (used with enhilo_EX)
//   regwrite_EX    : EX requests a register write
//   regsel_EX      : WB data source (ALU / HI / LO, 3 = ALU)
//   enhilo_EX      : load HI/LO at the end of EX
//   rdrt_EX        : destination select, 1 = rt, 0 = rd
//   GPIO_OUT       : load gpio_out from alu_lo_EX
//   GPIO_IN        : write the synchronized GPIO sample to the destination
//   flush_EX       : kill the EX instruction
//   gpio_in        : asynchronous external pins
//   regwrite_WB / regdest_WB / writedata_WB : register-file write port
//   hi_q, lo_q     : architectural HI/LO
//   gpio_out       : GPIO output register
// -----------------------------------------------------------------------------
module ex_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction_EX,
  input  logic [DATA_W-1:0]     alu_lo_EX,
  input  logic [DATA_W-1:0]     alu_hi_EX,
  input  logic                  regwrite_EX,
  input  logic [1:0]            regsel_EX,
  input  logic                  enhilo_EX,
  input  logic                  rdrt_EX,
  input  logic                  GPIO_OUT,
  input  logic                  GPIO_IN,
  input  logic                  flush_EX,
  input  logic [DATA_W-1:0]     gpio_in,
  output logic                  regwrite_WB,
  output logic [REG_ADDR_W-1:0] regdest_WB,
  output logic [DATA_W-1:0]     writedata_WB,
  output logic [DATA_W-1:0]     hi_q,
  output logic [DATA_W-1:0]     lo_q,
  output logic [DATA_W-1:0]     gpio_out
);

  logic [DATA_W-1:0]     gpio_sync_q;
  logic [REG_ADDR_W-1:0] dest_ex;
  logic                  live_ex;

  // WB-stage registered copies of the EX decode
  logic [1:0]            regsel_wb;
  logic                  gpio_in_wb;
  logic [DATA_W-1:0]     alu_wb;
  logic [DATA_W-1:0]     gpio_sample_wb;

  gpio_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .DATA_W      (DATA_W)
  ) u_gpio_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_in),
    .q   (gpio_sync_q)
  );

  assign live_ex = ~flush_EX;
  assign dest_ex = rdrt_EX ? instruction_EX[20:16] : instruction_EX[15:11];

  // EX->WB pipeline register. A killed instruction still moves through, but
  // with its write enable cleared so it lands in WB as a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_WB    <= 1'b0;
      regdest_WB     <= '0;
      regsel_wb      <= '0;
      gpio_in_wb     <= 1'b0;
      alu_wb         <= '0;
      gpio_sample_wb <= '0;
    end else begin
      regwrite_WB    <= regwrite_EX & live_ex & (dest_ex != REG_ZERO);
      regdest_WB     <= dest_ex;
      regsel_wb      <= regsel_EX;
      gpio_in_wb     <= GPIO_IN;
      alu_wb         <= alu_lo_EX;
      gpio_sample_wb <= gpio_sync_q;
    end
  end

  // HI/LO load at the end of EX so an mfhi/mflo in the next EX slot sees the
  // new value in its own WB cycle without a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (enhilo_EX && live_ex) begin
      hi_q <= alu_hi_EX;
      lo_q <= alu_lo_EX;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out <= '0;
    end else if (GPIO_OUT && live_ex) begin
      gpio_out <= alu_lo_EX;
    end
  end

  // GPIO read wins over regsel because the GPIO-read decode also drives
  // regsel = HI.
  always_comb begin
    writedata_WB = alu_wb;
    if (gpio_in_wb) begin
      writedata_WB = gpio_sample_wb;
    end else if (regsel_wb == REGSEL_HI) begin
      writedata_WB = hi_q;
    end else if (regsel_wb == REGSEL_LO) begin
      writedata_WB = lo_q;
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_wb_stage
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the stage (architectural HI/LO/GPIO state plus a delay
// line for the GPIO input pins).
// -----------------------------------------------------------------------------
module tb_ex_wb_stage;

  localparam int DW  = 32;
  localparam int SYN = 2;

  logic          clk;
  logic          rst;
  logic [31:0]   instruction_EX;
  logic [DW-1:0] alu_lo_EX;
  logic [DW-1:0] alu_hi_EX;
  logic          regwrite_EX;
  logic [1:0]    regsel_EX;
  logic          enhilo_EX;
  logic          rdrt_EX;
  logic          GPIO_OUT;
  logic          GPIO_IN;
  logic          flush_EX;
  logic [DW-1:0] gpio_in;
  logic          regwrite_WB;
  logic [4:0]    regdest_WB;
  logic [DW-1:0] writedata_WB;
  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;
  logic [DW-1:0] gpio_out;

  ex_wb_stage #(.DATA_W(DW), .SYNC_STAGES(SYN)) dut (
    .clk            (clk),
    .rst            (rst),
    .instruction_EX (instruction_EX),
    .alu_lo_EX      (alu_lo_EX),
    .alu_hi_EX      (alu_hi_EX),
    .regwrite_EX    (regwrite_EX),
    .regsel_EX      (regsel_EX),
    .enhilo_EX      (enhilo_EX),
    .rdrt_EX        (rdrt_EX),
    .GPIO_OUT       (GPIO_OUT),
    .GPIO_IN        (GPIO_IN),
    .flush_EX       (flush_EX),
    .gpio_in        (gpio_in),
    .regwrite_WB    (regwrite_WB),
    .regdest_WB     (regdest_WB),
    .writedata_WB   (writedata_WB),
    .hi_q           (hi_q),
    .lo_q           (lo_q),
    .gpio_out       (gpio_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_hi, m_lo, m_gout;
  logic [DW-1:0] exp_q[$];     // pin values still travelling through the synchronizer

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = '0;
    m_lo = '0;
    m_gout = '0;
    exp_q.delete();
    for (int i = 0; i < SYN; i++) exp_q.push_back('0);
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] rt, input logic [4:0] rd);
    return {11'd0, rt, rd, 11'd0};
  endfunction

  // Present one EX instruction, take the edge, advance the model and compare
  // every visible output. Called with the clock just past a rising edge.
  task automatic do_op(input logic [31:0] instr, input logic [31:0] lo, input logic [31:0] hi,
                       input logic we, input logic [1:0] sel, input logic enhl,
                       input logic rt_sel, input logic gout, input logic gin, input logic fl);
    logic [4:0]  dest;
    logic        exp_we;
    logic [31:0] sample, exp_data;
    instruction_EX = instr;
    alu_lo_EX      = lo;
    alu_hi_EX      = hi;
    regwrite_EX    = we;
    regsel_EX      = sel;
    enhilo_EX      = enhl;
    rdrt_EX        = rt_sel;
    GPIO_OUT       = gout;
    GPIO_IN        = gin;
    flush_EX       = fl;
    @(posedge clk);
    // model: pins sampled SYN edges ago are what the read sees now
    sample = exp_q.pop_front();
    exp_q.push_back(gpio_in);
    dest   = rt_sel ? instr[20:16] : instr[15:11];
    exp_we = we && !fl && (dest != 5'd0);
    if (enhl && !fl) begin
      m_hi = hi;
      m_lo = lo;
    end
    if (gout && !fl) m_gout = lo;
    if (gin)             exp_data = sample;
    else if (sel == 2'd1) exp_data = m_hi;
    else if (sel == 2'd2) exp_data = m_lo;
    else                  exp_data = lo;
    #1;
    check_eq("regwrite", {31'd0, regwrite_WB}, {31'd0, exp_we});
    if (exp_we) begin
      check_eq("regdest", {27'd0, regdest_WB}, {27'd0, dest});
      check_eq("writedata", writedata_WB, exp_data);
    end
    check_eq("hi_q", hi_q, m_hi);
    check_eq("lo_q", lo_q, m_lo);
    check_eq("gpio_out", gpio_out, m_gout);
  endtask

  task automatic idle();
    do_op(32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    instruction_EX = '0; alu_lo_EX = '0; alu_hi_EX = '0; regwrite_EX = 1'b0;
    regsel_EX = '0; enhilo_EX = 1'b0; rdrt_EX = 1'b0; GPIO_OUT = 1'b0;
    GPIO_IN = 1'b0; flush_EX = 1'b0; gpio_in = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_regwrite", {31'd0, regwrite_WB}, 32'd0);
    check_eq("rst_writedata", writedata_WB, 32'd0);
    check_eq("rst_gpio_out", gpio_out, 32'd0);
    #3 rst = 1'b1;
    @(posedge clk); #1;   // first edge after release: idle inputs, model shift
    void'(exp_q.pop_front());
    exp_q.push_back(gpio_in);

    // mult then mfhi / mflo
    do_op(32'd0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("mult_no_write", {31'd0, regwrite_WB}, 32'd0);
    do_op(mk_instr(5'd0, 5'd8), 32'd0, 32'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("mfhi_dest", {27'd0, regdest_WB}, 32'd8);
    check_eq("mfhi_data", writedata_WB, 32'h0000_0001);
    do_op(mk_instr(5'd0, 5'd9), 32'd0, 32'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("mflo_dest", {27'd0, regdest_WB}, 32'd9);
    check_eq("mflo_data", writedata_WB, 32'hFFFF_FFFE);

    // GPIO write, then hold through 10 idle cycles
    do_op(32'd0, 32'hA5A5_0000, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("gpio_write", gpio_out, 32'hA5A5_0000);
    repeat (10) idle();
    check_eq("gpio_hold", gpio_out, 32'hA5A5_0000);

    // GPIO read overrides regsel = HI while hi_q holds 0xDEAD
    gpio_in = 32'h1234_5678;
    do_op(32'd0, 32'd0, 32'h0000_DEAD, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) idle();
    do_op(mk_instr(5'd0, 5'd3), 32'd0, 32'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("gpio_read_data", writedata_WB, 32'h1234_5678);
    check_eq("gpio_read_dest", {27'd0, regdest_WB}, 32'd3);

    // destination select and $0 suppression
    do_op(mk_instr(5'd5, 5'd12), 32'd7, 32'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("addi_dest", {27'd0, regdest_WB}, 32'd5);
    check_eq("addi_data", writedata_WB, 32'd7);
    check_eq("addi_we", {31'd0, regwrite_WB}, 32'd1);
    do_op(mk_instr(5'd0, 5'd12), 32'd7, 32'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("addi_r0_we", {31'd0, regwrite_WB}, 32'd0);

    // flushed mult leaves HI/LO alone
    do_op(mk_instr(5'd0, 5'd4), 32'h1111_1111, 32'h2222_2222, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("flush_hi", hi_q, 32'h0000_DEAD);
    check_eq("flush_we", {31'd0, regwrite_WB}, 32'd0);

    // async reset mid-operation
    do_op(32'd0, 32'h0000_00FF, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(mk_instr(5'd0, 5'd6), 32'h0000_0000, 32'h0000_0055, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_hi", hi_q, 32'h0000_0055);
    check_eq("pre_rst_gpio", gpio_out, 32'h0000_00FF);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_regwrite", {31'd0, regwrite_WB}, 32'd0);
    check_eq("arst_regdest", {27'd0, regdest_WB}, 32'd0);
    check_eq("arst_writedata", writedata_WB, 32'd0);
    check_eq("arst_hi", hi_q, 32'd0);
    check_eq("arst_lo", lo_q, 32'd0);
    check_eq("arst_gpio", gpio_out, 32'd0);
    model_reset();
    #1 rst = 1'b1;
    do_op(mk_instr(5'd0, 5'd10), 32'hCAFE_0001, 32'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_data", writedata_WB, 32'hCAFE_0001);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      gpio_in = $urandom;
      do_op($urandom, $urandom, $urandom,
            $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
